// File: rtl/usart_receive_pkg.sv
// Shared UART definitions: receiver FSM encoding and baud-rate derivation
// (the divider and mid-bit point are also used by the transmitter).
package usart_receive_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // clocks per bit period
    function automatic int bps_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // counter value at which a bit is sampled (middle of the bit)
    function automatic int bps_half(input int clk_freq, input int baud);
        return (clk_freq / baud) / 2 - 1;
    endfunction

endpackage

// File: rtl/usart_receive_if.sv
// Receiver line/output bundle. master = receiver side, slave = line driver
// and consumer of received bytes.
interface usart_receive_if #(
    parameter int PORT_WID = 8
);
    logic                RXD;
    logic [PORT_WID-1:0] dataout;
    logic                RI;
    logic                frame_err;
    logic                parity_err;
    logic                busy;

    modport master (
        input  RXD,
        output dataout, RI, frame_err, parity_err, busy
    );

    modport slave (
        output RXD,
        input  dataout, RI, frame_err, parity_err, busy
    );
endinterface

// File: rtl/usart_rx_bps.sv
// Baud counter for the receiver: counts 0..BPS_DIV-1 while run is high,
// held at 0 otherwise, and strobes sample at the mid-bit count.
module usart_rx_bps
    import usart_receive_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sample
);
    localparam int DIV  = bps_div(CLK_FREQ, BAUD);
    localparam int HALF = bps_half(CLK_FREQ, BAUD);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // free-running bit-period counter, cleared whenever the receiver is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt <= '0;
        else if (!run)                cnt <= '0;
        else if (cnt == CW'(DIV - 1)) cnt <= '0;
        else                          cnt <= cnt + 1'b1;
    end

    assign sample = run && (cnt == CW'(HALF));

endmodule

// File: rtl/usart_receive.sv
// UART receiver: 2-flop RXD synchronizer, start-edge detect, LSB-first
// shift register and frame checks. Optional even parity bit is enabled with
// macro USART_RX_PARITY_EN (default build: 8N1, parity_err tied low).
module usart_receive
    import usart_receive_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int PORT_WID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    usart_receive_if.master bus
);
    localparam int BW = $clog2(PORT_WID + 1);

`ifdef USART_RX_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic                rx_s1, rx_s2, rx_prev;
    logic                fall;
    logic [2:0]          state;
    logic [BW-1:0]       bit_cnt;
    logic [PORT_WID-1:0] shreg;
    logic [PORT_WID-1:0] dout;
    logic                ri, fe;
    logic                run, sample;

    // synchronize RXD; rx_prev gives the previous synchronized value for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // a start needs a real high-to-low edge, so a held-low break never retriggers
    assign fall = rx_prev & ~rx_s2;
    assign run  = (state != ST_IDLE);

    usart_rx_bps #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_bps (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .sample (sample)
    );

    // frame FSM, shift register and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            dout    <= '0;
            ri      <= 1'b0;
            fe      <= 1'b0;
        end else begin
            ri <= 1'b0;
            fe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (fall) state <= ST_START;
                end
                ST_START: begin
                    // line back high at mid start bit: glitch, not a frame
                    if (sample) state <= rx_s2 ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample) begin
                        shreg <= {rx_s2, shreg[PORT_WID-1:1]};
                        if (bit_cnt == BW'(PORT_WID - 1)) begin
                            bit_cnt <= '0;
                            state   <= ST_AFTER_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) state <= ST_STOP;
                end
                ST_STOP: begin
                    // back to IDLE at mid stop bit so a following start edge is caught
                    if (sample) begin
                        state <= ST_IDLE;
                        if (rx_s2) begin
                            dout <= shreg;
                            ri   <= 1'b1;
                        end else begin
                            fe   <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef USART_RX_PARITY_EN
    logic par_bad, pe;

    // even parity check; reported alongside the stop-bit result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad <= 1'b0;
            pe      <= 1'b0;
        end else begin
            pe <= 1'b0;
            if (state == ST_IDLE)
                par_bad <= 1'b0;
            else if (state == ST_PARITY && sample)
                par_bad <= rx_s2 ^ (^shreg);
            if (state == ST_STOP && sample)
                pe <= par_bad;
        end
    end

    assign bus.parity_err = pe;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.dataout   = dout;
    assign bus.RI        = ri;
    assign bus.frame_err = fe;
    assign bus.busy      = run;

endmodule

// File: tb/tb_usart_receive.sv
// Scoreboard bench for usart_receive at CLK_FREQ=1 MHz, BAUD=100 kHz (10 clk/bit).
module tb_usart_receive;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int W        = 8;
    localparam int DIV      = 10;
`ifdef USART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // start driven at negedge c0: sync(2) + edge detect(1) + START entry(1)
    // + 4 counts to mid-bit = sample edge 8; stop bit index 9+PAR; pulse
    // visible on the negedge after the stop sample edge.
    localparam int PULSE_LAT = 8 + DIV * (9 + PAR);

    typedef struct {
        logic       is_ri;
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] model_dout = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    usart_receive_if #(.PORT_WID(W)) bus();

    usart_receive #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .PORT_WID (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (bus.RI || bus.frame_err || bus.parity_err)) begin
            if (bus.RI && bus.frame_err) chk("ri_fe_exclusive", 1, 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {bus.RI, bus.frame_err, bus.parity_err}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_ri",  bus.RI, mon_e.is_ri);
                chk("pulse_fe",  bus.frame_err, !mon_e.is_ri);
                chk("dataout",   bus.dataout, mon_e.data);
                chk("parity",    bus.parity_err, mon_e.perr);
                chk("latency",   cyc, mon_e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // drive one frame starting at the current negedge; pflip inverts the parity bit
    task automatic send(input logic [7:0] d, input logic stopb, input logic pflip);
        exp_t e;
        if (stopb) model_dout = d;
        e.is_ri = stopb;
        e.data  = model_dout;
        e.perr  = (PAR != 0) ? pflip : 1'b0;
        e.cyc   = cyc + PULSE_LAT;
        sb.push_back(e);
        bus.RXD = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            bus.RXD = d[i];
            idle(DIV);
        end
        if (PAR != 0) begin
            bus.RXD = (^d) ^ pflip;
            idle(DIV);
        end
        bus.RXD = stopb;
        idle(DIV);
    endtask

    initial begin
        bus.RXD = 1'b1;
        idle(3);
        chk("rst_dataout", bus.dataout, 0);
        chk("rst_ri",      bus.RI, 0);
        chk("rst_fe",      bus.frame_err, 0);
        chk("rst_pe",      bus.parity_err, 0);
        chk("rst_busy",    bus.busy, 0);
        rst_n = 1'b1;
        idle(5);

        // clean frame
        send(8'h5A, 1'b1, 1'b0);
        idle(15);
        chk("hold_5a", bus.dataout, 8'h5A);

        // false start: 3 cycles low
        bus.RXD = 1'b0;
        idle(3);
        bus.RXD = 1'b1;
        idle(4);
        chk("false_start_busy", bus.busy, 1);
        idle(1);
        chk("false_start_idle", bus.busy, 0);
        idle(20);

        // frame error, then line held low (break)
        send(8'hA5, 1'b0, 1'b0);
        idle(30);
        chk("break_busy", bus.busy, 0);
        chk("break_dataout", bus.dataout, 8'h5A);
        bus.RXD = 1'b1;
        idle(20);

        // back-to-back frames, no idle gap
        send(8'h01, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        idle(20);

`ifdef USART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b1);
        idle(20);
`endif

        // reset in the middle of data bit 4 of 0x3C
        bus.RXD = 1'b0;
        idle(DIV);
        for (int i = 0; i < 4; i++) begin
            bus.RXD = 8'h3C >> i;
            idle(DIV);
        end
        bus.RXD = 1'b1;
        idle(5);
        rst_n = 1'b0;
        idle(1);
        chk("midrst_busy",    bus.busy, 0);
        chk("midrst_dataout", bus.dataout, 0);
        idle(3);
        rst_n = 1'b1;
        model_dout = 8'h00;
        idle(20);
        chk("post_rst_busy", bus.busy, 0);
        send(8'h81, 1'b1, 1'b0);

        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        chk("sb_drained", sb.size(), 0);
        idle(5);
        chk("final_dataout", bus.dataout, 8'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usart_receive.md
USART_RECEIVE -- requirements
Module: usart_receive

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 The block SHALL have parameter PORT_WID, default 8, meaning data bits per frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port RXD, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-007 The block SHALL have port dataout, output, PORT_WID bits: last correctly received byte.
REQ-008 The block SHALL have port RI, output, 1 bit: one-cycle pulse, new byte valid on dataout.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-010 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse, parity mismatch.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 BPS_DIV SHALL equal CLK_FREQ/BAUD (integer division); the mid-bit sample point SHALL be bit counter value BPS_DIV/2-1.
REQ-013 RXD SHALL pass through a 2-flop synchronizer, both flops reset to 1; all logic SHALL use the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE->START SHALL occur on a synchronized high-to-low transition; the baud counter SHALL clear to 0 on entry.
REQ-016 The baud counter SHALL count 0..BPS_DIV-1 and wrap, running only outside IDLE.
REQ-017 In START, at the first sample point: a sampled 0 SHALL go to DATA; a sampled 1 SHALL return to IDLE (false start) with no output pulses.
REQ-018 DATA SHALL sample PORT_WID bits LSB first, one per wrapped bit period, into a shift register; after the last bit the FSM SHALL go to PARITY when enabled, else to STOP.
REQ-019 In STOP, at the sample point, a sampled 1 SHALL load dataout and pulse RI the next cycle; a sampled 0 SHALL pulse frame_err the next cycle with dataout unchanged and RI low.
REQ-020 The FSM SHALL return to IDLE at the stop-bit sample point, so a new start edge is accepted from the middle of the stop bit.
REQ-021 After a frame error with RXD held low (break), no new frame SHALL start until RXD has gone high and then low again.
REQ-022 RI and frame_err SHALL never assert in the same cycle; parity_err MAY coincide with RI.
REQ-023 A change on RXD outside sample points SHALL not affect the received data (glitch tolerance at sample points only).

Reset
REQ-024 On rst_n low, asynchronously: state IDLE, counters 0, shift register 0, dataout 0, RI 0, frame_err 0, parity_err 0, busy 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release the block SHALL wait for a fresh falling edge.

Configuration
REQ-026 With macro USART_RX_PARITY_EN defined, the frame SHALL carry one even-parity bit after the data bits, sampled in PARITY; a mismatch SHALL pulse parity_err in the same cycle RI or frame_err would pulse.
REQ-027 Without USART_RX_PARITY_EN, the PARITY state SHALL be unreachable, frames SHALL be 8N1, and parity_err SHALL be tied to 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the BPS_DIV/half-point derivation shared with the transmitter.
REQ-029 The baud counter with sample-point strobe SHALL be a sub-module named usart_rx_bps; the FSM and shift register SHALL stay in usart_receive.

Verification (CLK_FREQ=1000000, BAUD=100000, BPS_DIV=10)
REQ-030 Frame 0x5A, 8N1, clean -> dataout=0x5A, RI pulses once, one cycle after the stop-bit sample point; frame_err stays 0.
REQ-031 RXD low for 3 cycles, then high -> no state advance beyond START; busy clears at the sample point; no pulses.
REQ-032 Frame 0xA5 with stop bit 0 -> frame_err one pulse; dataout keeps the previous value; RI stays 0.
REQ-033 Two back-to-back frames 0x01, 0xFF with no idle gap -> two RI pulses, dataout 0x01 then 0xFF.
REQ-034 With USART_RX_PARITY_EN, frame 0x03 with parity bit 1 -> RI and parity_err pulse together, dataout=0x03.
REQ-035 rst_n low during data bit 4 of frame 0x3C, then a clean frame 0x81 -> no pulse for 0x3C; dataout=0x81 with RI pulse.
